rca_seq_ctrl: RTL and testbench

Sequencing controller for multi-precision addition. It accepts WIDTH-bit operands over a valid/ready handshake and feeds them one SLICE-bit chunk per cycle, LSB chunk first, through a single shared ripple-carry slice, holding the inter-slice carry in a register. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It trades the area of a full-width ripple-carry adder for NSLICE cycles of latency, and is the sequenced counterpart of the 80-bit adder built from 40-bit halves.

---
 rtl/rca_pkg.sv | 19 +
 rtl/rca_seq_ctrl_if.sv | 30 +++
 rtl/rca_slice.sv | 30 +++
 rtl/rca_seq_ctrl.sv | 116 +++++++++++
 tb/tb_rca_seq_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rca_pkg
//  Description : Shared types and default sizes for the sequenced adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

    localparam int WIDTH_DEF = 80;
    localparam int SLICE_DEF = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : rca_pkg
`default_nettype wire

// File: rtl/rca_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rca_seq_ctrl_if
//  Description : Operand request and result handshakes of the sequenced adder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rca_seq_ctrl_if #(
    parameter int WIDTH = rca_pkg::WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface : rca_seq_ctrl_if
`default_nettype wire

// File: rtl/rca_slice.sv
`default_nettype none
// ============================================================================
//  Module      : rca_slice
//  Description : SLICE-bit combinational ripple-carry adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_slice #(
    parameter int SLICE = rca_pkg::SLICE_DEF
) (
    input  wire logic [SLICE-1:0] a,
    input  wire logic [SLICE-1:0] b,
    input  wire logic             cin,
    output logic      [SLICE-1:0] s,
    output logic                  cout
);

    logic w_c;

    always_comb begin
        s   = '0;
        w_c = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        cout = w_c;
    end

endmodule : rca_slice
`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rca_seq_ctrl
//  Description : Multi-precision adder that walks one shared ripple slice
//                across the operands, LSB chunk first, carry held in a reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rca_seq_ctrl_if.slave   bus,
    output logic            busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NSLICE - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_s;
    logic             w_c;

    assign w_a_sl = r_a[r_idx*SLICE +: SLICE];
    assign w_b_sl = r_b[r_idx*SLICE +: SLICE];

    rca_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (w_a_sl),
        .b    (w_b_sl),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // Handshake flags are registered alongside the state so that no input
    // ever reaches in_ready/out_valid/busy combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.cin;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[r_idx*SLICE +: SLICE] <= w_s;
                    r_carry                     <= w_c;
                    if (r_idx == c_last_idx) begin
                        r_cout      <= w_c;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign busy          = r_busy;

endmodule : rca_seq_ctrl
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_seq_ctrl
//  Description : Directed and randomised self-checking bench for rca_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_seq_ctrl;
    import rca_pkg::*;

    localparam int WIDTH  = 80;
    localparam int SLICE  = 40;
    localparam int NSLICE = WIDTH / SLICE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   last_acc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rca_seq_ctrl #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic checkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return WIDTH'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Called at a falling edge; leaves the bench at a falling edge with the
    // controller back in IDLE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input int hold, input bit chk_gap);
        logic [WIDTH:0] ref_v;
        int n;
        ref_v = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkb("in_ready_idle", bus.in_ready, 1'b1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        if (chk_gap && last_acc >= 0)
            checkb("issue_interval_ge", (cyc - last_acc) >= NSLICE + 2, 1'b1);
        last_acc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = rnd_word();
        bus.b        = rnd_word();
        bus.cin      = ~cin;
        checkb("in_ready_run", bus.in_ready, 1'b0);
        checkb("busy_run", busy, 1'b1);
        checkb("out_valid_run", bus.out_valid, 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checki("latency", n, NSLICE);
        checkw("sum", bus.sum, ref_v[WIDTH-1:0]);
        checkb("cout", bus.cout, ref_v[WIDTH]);
        checkb("in_ready_done", bus.in_ready, 1'b0);
        checkb("busy_done", busy, 1'b1);
        repeat (hold) begin
            bus.a = rnd_word();
            bus.b = rnd_word();
            @(negedge clk);
            checkb("hold_out_valid", bus.out_valid, 1'b1);
            checkw("hold_sum", bus.sum, ref_v[WIDTH-1:0]);
            checkb("hold_cout", bus.cout, ref_v[WIDTH]);
            checkb("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        checkb("in_ready_handshake", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkb("out_valid_after", bus.out_valid, 1'b0);
        checkb("busy_after", busy, 1'b0);
        checkb("in_ready_after", bus.in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded limit");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        checkb("rst_in_ready", bus.in_ready, 1'b1);
        checkb("rst_out_valid", bus.out_valid, 1'b0);
        checkb("rst_busy", busy, 1'b0);
        checkw("rst_sum", bus.sum, '0);
        checkb("rst_cout", bus.cout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(80'h0, 80'h0, 1'b0, 0, 1'b0);
        run_op(80'hFFFFFFFFFFFFFFFFFFFF, 80'h0, 1'b1, 0, 1'b0);
        run_op(80'h80000000000000000000, 80'h80000000000000000000, 1'b0, 0, 1'b0);
        run_op(80'h7FFFFFFFFFFFFFFFFFFF, 80'h7FFFFFFFFFFFFFFFFFFF, 1'b0, 0, 1'b0);
        run_op(80'h1, 80'h1, 1'b1, 5, 1'b0);
        checkw("bp_sum_literal", 80'h3, {{(WIDTH-2){1'b0}}, 2'b11} & bus.sum);

        // Abort in the middle of RUN.
        bus.a        = 80'hFFFFFFFFFFFFFFFFFFFF;
        bus.b        = 80'h1;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkb("pre_abort_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkb("abort_out_valid", bus.out_valid, 1'b0);
        checkb("abort_busy", busy, 1'b0);
        checkw("abort_sum", bus.sum, '0);
        checkb("abort_cout", bus.cout, 1'b0);
        checkb("abort_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkb("post_abort_out_valid", bus.out_valid, 1'b0);
        run_op(80'h123456789ABCDEF01234, 80'hFEDCBA9876543210FEDC, 1'b1, 1, 1'b0);

        last_acc = -1;
        for (int i = 0; i < 200; i++)
            run_op(rnd_word(), rnd_word(), 1'($urandom()), int'($urandom_range(0, 3)), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rca_seq_ctrl
`default_nettype wire
